// File: rtl/branch_resolve_unit.sv
// Execute-side branch resolution: checks carried fetch predictions against EX outcomes,
// issues redirect + multi-cycle flush on mispredict, and emits predictor training updates.
module branch_resolve_unit #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 if_valid,
    input  logic [31:0]          if_pc,
    input  logic                 if_pred_taken,
    input  logic [31:0]          if_pred_target,
    input  logic                 ex_valid,
    input  logic                 ex_is_branch,
    input  logic                 ex_taken,
    input  logic [31:0]          ex_target,
    output logic                 redirect_valid,
    output logic [31:0]          redirect_pc,
    output logic                 flush,
    output logic                 upd_en,
    output logic [31:0]          upd_pc,
    output logic                 upd_taken,
    output logic [31:0]          upd_target,
    output logic [CNT_WIDTH-1:0] branch_cnt,
    output logic [CNT_WIDTH-1:0] mispredict_cnt
);

    typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

    state_t      state, state_next;
    logic [2:0]  flush_ctr, flush_ctr_next;

    // Metadata pipe: entry 0 is ID, entry 1 is EX
    logic        id_valid, ex_entry_valid;
    logic [31:0] id_pc, ex_entry_pc;
    logic        id_pred_taken, ex_entry_pred_taken;
    logic [31:0] id_pred_target, ex_entry_pred_target;

    logic        resolve;
    logic        mispredict;
    logic [31:0] correct_pc;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    // Resolution and mispredict detection for the EX entry
    always_comb begin
        resolve    = (state == IDLE) && !stall && ex_valid && ex_entry_valid;
        mispredict = 1'b0;
        if (resolve) begin
            if (ex_is_branch) begin
                mispredict = (ex_entry_pred_taken != ex_taken) ||
                             (ex_entry_pred_taken && ex_taken && (ex_entry_pred_target != ex_target));
            end else begin
                mispredict = ex_entry_pred_taken;
            end
        end else begin
            mispredict = 1'b0;
        end
        // A non-branch alias always falls through to pc+4
        if (ex_is_branch && ex_taken) begin
            correct_pc = ex_target;
        end else begin
            correct_pc = ex_entry_pc + 32'd4;
        end
    end

    // Next-state logic for the flush sequencer
    always_comb begin
        state_next     = state;
        flush_ctr_next = flush_ctr;
        case (state)
            IDLE: begin
                if (mispredict) begin
                    state_next     = FLUSH;
                    flush_ctr_next = 3'(FLUSH_CYCLES - 1);
                end else begin
                    state_next = IDLE;
                end
            end
            FLUSH: begin
                if (flush_ctr == 3'd0) begin
                    state_next = IDLE;
                end else begin
                    flush_ctr_next = flush_ctr - 3'd1;
                end
            end
            default: begin
                state_next     = IDLE;
                flush_ctr_next = 3'd0;
            end
        endcase
    end

    // Flush sequencer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            flush_ctr <= 3'd0;
            flush     <= 1'b0;
        end else begin
            state     <= state_next;
            flush_ctr <= flush_ctr_next;
            flush     <= (state_next == FLUSH);
        end
    end

    // Prediction metadata pipe IF->ID->EX; squashed while flushing
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            id_valid             <= 1'b0;
            id_pc                <= 32'd0;
            id_pred_taken        <= 1'b0;
            id_pred_target       <= 32'd0;
            ex_entry_valid       <= 1'b0;
            ex_entry_pc          <= 32'd0;
            ex_entry_pred_taken  <= 1'b0;
            ex_entry_pred_target <= 32'd0;
        end else if (!stall) begin
            id_valid             <= if_valid;
            id_pc                <= if_pc;
            id_pred_taken        <= if_pred_taken;
            id_pred_target       <= if_pred_target;
            ex_entry_valid       <= id_valid;
            ex_entry_pc          <= id_pc;
            ex_entry_pred_taken  <= id_pred_taken;
            ex_entry_pred_target <= id_pred_target;
        end
    end

    // Registered redirect, training update and saturating statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
            upd_en         <= 1'b0;
            upd_pc         <= 32'd0;
            upd_taken      <= 1'b0;
            upd_target     <= 32'd0;
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else begin
            redirect_valid <= mispredict;
            upd_en         <= resolve && ex_is_branch;
            if (mispredict) begin
                redirect_pc <= correct_pc;
                if (mispredict_cnt != CNT_MAX) begin
                    mispredict_cnt <= mispredict_cnt + CNT_ONE;
                end
            end
            if (resolve && ex_is_branch) begin
                upd_pc     <= ex_entry_pc;
                upd_taken  <= ex_taken;
                upd_target <= ex_target;
                if (branch_cnt != CNT_MAX) begin
                    branch_cnt <= branch_cnt + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: a 16-bit-counter instance and a 4-bit-counter
// instance share stimulus; a behavioural model is checked every cycle, plus literal pins.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst, stall, if_valid, if_pred_taken, ex_valid, ex_is_branch, ex_taken;
    logic [31:0] if_pc, if_pred_target, ex_target;

    logic        a_rv, a_flush, a_ue, a_ut;
    logic [31:0] a_rpc, a_upc, a_utg;
    logic [15:0] a_bcnt, a_mcnt;
    logic        b_rv, b_flush, b_ue, b_ut;
    logic [31:0] b_rpc, b_upc, b_utg;
    logic [3:0]  b_bcnt, b_mcnt;

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;

    // Model state: fetched-instruction slots, flush cycles left, event counts, held outputs
    bit          m_v[2];
    logic [31:0] m_pc[2], m_tg[2];
    bit          m_pt[2];
    int          m_flush_left, m_bcnt, m_mcnt;
    bit          e_rv, e_ue, e_ut;
    logic [31:0] e_rpc, e_upc, e_utg;

    always #5 clk = ~clk;

    branch_resolve_unit dut16 (
        .clk(clk), .rst(rst), .stall(stall), .if_valid(if_valid), .if_pc(if_pc),
        .if_pred_taken(if_pred_taken), .if_pred_target(if_pred_target),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_taken(ex_taken),
        .ex_target(ex_target), .redirect_valid(a_rv), .redirect_pc(a_rpc),
        .flush(a_flush), .upd_en(a_ue), .upd_pc(a_upc), .upd_taken(a_ut),
        .upd_target(a_utg), .branch_cnt(a_bcnt), .mispredict_cnt(a_mcnt)
    );

    branch_resolve_unit #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .stall(stall), .if_valid(if_valid), .if_pc(if_pc),
        .if_pred_taken(if_pred_taken), .if_pred_target(if_pred_target),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_taken(ex_taken),
        .ex_target(ex_target), .redirect_valid(b_rv), .redirect_pc(b_rpc),
        .flush(b_flush), .upd_en(b_ue), .upd_pc(b_upc), .upd_taken(b_ut),
        .upd_target(b_utg), .branch_cnt(b_bcnt), .mispredict_cnt(b_mcnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    // Apply the rules to the inputs held across the edge just taken
    task automatic model_update();
        bit flushing, res, mis;
        logic [31:0] corr;
        if (rst) begin
            m_v[0] = 1'b0; m_v[1] = 1'b0;
            m_flush_left = 0; m_bcnt = 0; m_mcnt = 0;
            e_rv = 1'b0; e_ue = 1'b0; e_ut = 1'b0;
            e_rpc = 32'd0; e_upc = 32'd0; e_utg = 32'd0;
        end else begin
            flushing = (m_flush_left > 0);
            res  = !flushing && !stall && ex_valid && m_v[1];
            mis  = 1'b0;
            corr = 32'd0;
            e_rv = 1'b0;
            e_ue = 1'b0;
            if (res) begin
                if (ex_is_branch) begin
                    m_bcnt++;
                    e_ue = 1'b1; e_upc = m_pc[1]; e_ut = ex_taken; e_utg = ex_target;
                    mis  = (m_pt[1] != ex_taken) || (m_pt[1] && ex_taken && m_tg[1] != ex_target);
                    corr = ex_taken ? ex_target : m_pc[1] + 32'd4;
                end else begin
                    mis  = m_pt[1];
                    corr = m_pc[1] + 32'd4;
                end
                if (mis) begin
                    m_mcnt++;
                    e_rv = 1'b1;
                    e_rpc = corr;
                end
            end
            if (flushing) begin
                m_v[0] = 1'b0; m_v[1] = 1'b0;
                m_flush_left--;
            end else if (!stall) begin
                m_v[1] = m_v[0]; m_pc[1] = m_pc[0]; m_pt[1] = m_pt[0]; m_tg[1] = m_tg[0];
                m_v[0] = if_valid; m_pc[0] = if_pc; m_pt[0] = if_pred_taken; m_tg[0] = if_pred_target;
            end
            if (mis) m_flush_left = 2;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        armed = 1'b1;
    endtask

    task automatic idle_inputs();
        if_valid = 1'b0; if_pc = 32'd0; if_pred_taken = 1'b0; if_pred_target = 32'd0;
        ex_valid = 1'b0; ex_is_branch = 1'b0; ex_taken = 1'b0; ex_target = 32'd0;
    endtask

    task automatic idle(input int n);
        idle_inputs();
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic fetch(input logic [31:0] pc, input logic pt, input logic [31:0] ptg);
        idle_inputs();
        if_valid = 1'b1; if_pc = pc; if_pred_taken = pt; if_pred_target = ptg;
    endtask

    task automatic drive_ex(input logic isb, input logic tk, input logic [31:0] tg);
        idle_inputs();
        ex_valid = 1'b1; ex_is_branch = isb; ex_taken = tk; ex_target = tg;
    endtask

    // Fetch one instruction, let it reach EX, resolve it; returns after the resolving edge
    task automatic run_branch(input logic [31:0] pc, input logic pt, input logic [31:0] ptg,
                              input logic isb, input logic tk, input logic [31:0] tg);
        fetch(pc, pt, ptg);
        step();
        idle_inputs();
        step();
        drive_ex(isb, tk, tg);
        step();
        idle_inputs();
    endtask

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (armed) begin
            check("flush",          {31'd0, a_flush}, {31'd0, m_flush_left > 0});
            check("redirect_valid", {31'd0, a_rv},    {31'd0, e_rv});
            check("redirect_pc",    a_rpc,            e_rpc);
            check("upd_en",         {31'd0, a_ue},    {31'd0, e_ue});
            check("upd_pc",         a_upc,            e_upc);
            check("upd_taken",      {31'd0, a_ut},    {31'd0, e_ut});
            check("upd_target",     a_utg,            e_utg);
            check("branch_cnt",     {16'd0, a_bcnt},  32'(sat(m_bcnt, 65535)));
            check("mispredict_cnt", {16'd0, a_mcnt},  32'(sat(m_mcnt, 65535)));
            check("w4_flush",       {31'd0, b_flush}, {31'd0, m_flush_left > 0});
            check("w4_branch_cnt",  {28'd0, b_bcnt},  32'(sat(m_bcnt, 15)));
            check("w4_mispred_cnt", {28'd0, b_mcnt},  32'(sat(m_mcnt, 15)));
        end
    end

    initial begin
        rst = 1'b1; stall = 1'b0;
        idle_inputs();
        step();
        step();
        check("rst_flush",  {31'd0, a_flush}, 32'd0);
        check("rst_rpc",    a_rpc,            32'd0);
        check("rst_bcnt",   {16'd0, a_bcnt},  32'd0);
        rst = 1'b0;
        idle(1);

        // correct prediction
        run_branch(32'h100, 1'b1, 32'h140, 1'b1, 1'b1, 32'h140);
        check("ok_upd_en",  {31'd0, a_ue},    32'd1);
        check("ok_upd_pc",  a_upc,            32'h100);
        check("ok_upd_tk",  {31'd0, a_ut},    32'd1);
        check("ok_rv",      {31'd0, a_rv},    32'd0);
        check("ok_flush",   {31'd0, a_flush}, 32'd0);
        check("ok_bcnt",    {16'd0, a_bcnt},  32'd1);
        check("ok_mcnt",    {16'd0, a_mcnt},  32'd0);
        idle(1);

        // direction mispredict, with a younger branch reaching EX during the flush
        fetch(32'h200, 1'b0, 32'h0);
        step();
        fetch(32'h204, 1'b0, 32'h0);
        step();
        drive_ex(1'b1, 1'b1, 32'h180);
        step();
        check("dir_rv",     {31'd0, a_rv},    32'd1);
        check("dir_rpc",    a_rpc,            32'h180);
        check("dir_flush",  {31'd0, a_flush}, 32'd1);
        check("dir_mcnt",   {16'd0, a_mcnt},  32'd1);
        drive_ex(1'b1, 1'b1, 32'h999);
        step();
        check("fl_upd_en",  {31'd0, a_ue},    32'd0);
        check("fl_rv",      {31'd0, a_rv},    32'd0);
        check("fl_flush1",  {31'd0, a_flush}, 32'd1);
        check("fl_bcnt",    {16'd0, a_bcnt},  32'd2);
        idle(1);
        check("fl_flush2",  {31'd0, a_flush}, 32'd0);

        // target mispredict
        run_branch(32'h2F0, 1'b1, 32'h300, 1'b1, 1'b1, 32'h340);
        check("tgt_rpc",    a_rpc,            32'h340);
        check("tgt_mcnt",   {16'd0, a_mcnt},  32'd2);
        idle(2);

        // fall-through wraps at the top of the address space
        run_branch(32'hFFFFFFFC, 1'b1, 32'h10, 1'b1, 1'b0, 32'h20);
        check("wrap_rv",    {31'd0, a_rv},    32'd1);
        check("wrap_rpc",   a_rpc,            32'h0);
        idle(2);

        // BTB alias on a non-branch
        run_branch(32'h400, 1'b1, 32'h500, 1'b0, 1'b0, 32'h0);
        check("alias_rpc",  a_rpc,            32'h404);
        check("alias_ue",   {31'd0, a_ue},    32'd0);
        check("alias_bcnt", {16'd0, a_bcnt},  32'd4);
        check("alias_mcnt", {16'd0, a_mcnt},  32'd4);
        idle(2);

        // stall holds a mispredicting EX entry
        fetch(32'h600, 1'b0, 32'h0);
        step();
        idle(1);
        drive_ex(1'b1, 1'b1, 32'h680);
        stall = 1'b1;
        step();
        check("stall_rv1",  {31'd0, a_rv},    32'd0);
        step();
        check("stall_rv2",  {31'd0, a_rv},    32'd0);
        stall = 1'b0;
        step();
        check("stall_rv3",  {31'd0, a_rv},    32'd1);
        check("stall_rpc",  a_rpc,            32'h680);

        // reset during the first flush cycle
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rfl_flush",  {31'd0, a_flush}, 32'd0);
        check("rfl_bcnt",   {16'd0, a_bcnt},  32'd0);
        check("rfl_mcnt",   {16'd0, a_mcnt},  32'd0);
        idle(1);

        // saturation of the narrow counter
        for (int i = 0; i < 20; i++) begin
            run_branch(32'h1000 + 32'(i * 16), 1'b0, 32'h0, 1'b1, 1'b0, 32'h2000);
        end
        idle(1);
        check("sat_w4_bcnt",  {28'd0, b_bcnt}, 32'd15);
        check("sat_w16_bcnt", {16'd0, a_bcnt}, 32'd20);
        check("sat_w4_mcnt",  {28'd0, b_mcnt}, 32'd0);

        armed = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
